// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: data-memory access over req/gnt/rvalid, load alignment and extension,
// and register-file write port. Upstream is stalled while a memory transaction is outstanding.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_in,
  input  logic [31:0] pc_plus_4_in,
  input  logic [31:0] iadder_in,
  input  logic [2:0]  wb_mux_sel_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic        rf_wr_en_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [3:0]  dmem_be_out,
  output logic [31:0] dmem_wdata_out,
  input  logic        dmem_gnt_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        rf_wr_en_out,
  output logic [4:0]  rf_rd_addr_out,
  output logic [31:0] rf_wr_data_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [4:0]        rd_q, rd_d;
  logic [1:0]        size_q, size_d, off_q, off_d;
  logic              uns_q, uns_d, ld_q, ld_d, wen_q, wen_d;
  logic              rf_wr_en_q, rf_wr_en_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [4:0]        rf_rd_addr_q, rf_rd_addr_d;
  logic [31:0]       rf_wr_data_q, rf_wr_data_d;

  logic        transfer, mem_op, misaligned, start;
  logic        last_cycle, store_done, load_done, done, timeout;
  logic [31:0] wb_data, be_wdata, lane_shift, load_data;
  logic [3:0]  be_calc;
  logic [15:0] lane_half;

  assign transfer   = valid_in & (state_q == StIdle);
  assign mem_op     = is_load_in | is_store_in;
  assign misaligned = ((load_size_in == 2'b01) & alu_result_in[0]) |
                      (load_size_in[1] & (|alu_result_in[1:0]));
  assign start      = transfer & mem_op & ~misaligned;
  assign last_cycle = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign store_done = (state_q == StReq) & ~ld_q & dmem_gnt_in;
  // Zero-wait memory: rvalid alongside gnt completes the load directly from REQ.
  assign load_done  = (((state_q == StReq) & dmem_gnt_in) | (state_q == StWait)) & ld_q &
                      dmem_rvalid_in;
  assign done       = store_done | load_done;
  assign timeout    = (state_q != StIdle) & ~done & last_cycle;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rd_q         <= '0;
      size_q       <= '0;
      off_q        <= '0;
      uns_q        <= 1'b0;
      ld_q         <= 1'b0;
      wen_q        <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_wr_data_q <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rd_q         <= rd_d;
      size_q       <= size_d;
      off_q        <= off_d;
      uns_q        <= uns_d;
      ld_q         <= ld_d;
      wen_q        <= wen_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          cnt_d   = '0;
        end
      end
      StReq: begin
        if (done || timeout) begin
          state_d = StIdle;
        end else begin
          if (dmem_gnt_in) state_d = StWait;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWait: begin
        if (done || timeout) state_d = StIdle;
        else                 cnt_d   = cnt_q + CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (wb_mux_sel_in)
      3'b010:  wb_data = iadder_in;
      3'b011:  wb_data = pc_plus_4_in;
      default: wb_data = alu_result_in;
    endcase
    case (load_size_in)
      2'b00:   be_calc = 4'b0001 << alu_result_in[1:0];
      2'b01:   be_calc = alu_result_in[1] ? 4'b1100 : 4'b0011;
      default: be_calc = 4'b1111;
    endcase
    case (load_size_in)
      2'b00:   be_wdata = {4{rs2_in[7:0]}};
      2'b01:   be_wdata = {2{rs2_in[15:0]}};
      default: be_wdata = rs2_in;
    endcase
    lane_shift = dmem_rdata_in >> {off_q, 3'b000};
    lane_half  = off_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & lane_shift[7]}}, lane_shift[7:0]};
      2'b01:   load_data = {{16{~uns_q & lane_half[15]}}, lane_half};
      default: load_data = dmem_rdata_in;
    endcase
  end

  always_comb begin
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rd_d         = rd_q;
    size_d       = size_q;
    off_d        = off_q;
    uns_d        = uns_q;
    ld_d         = ld_q;
    wen_d        = wen_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    if (transfer) begin
      if (!mem_op) begin
        rf_wr_en_d   = rf_wr_en_in & (|rd_addr_in);
        rf_rd_addr_d = rd_addr_in;
        rf_wr_data_d = wb_data;
      end else if (misaligned) begin
        misalign_d = 1'b1;
      end else begin
        req_d   = 1'b1;
        we_d    = ~is_load_in;
        addr_d  = {alu_result_in[31:2], 2'b00};
        be_d    = be_calc;
        wdata_d = is_load_in ? 32'h0 : be_wdata;
        rd_d    = rd_addr_in;
        size_d  = load_size_in;
        off_d   = alu_result_in[1:0];
        uns_d   = load_unsigned_in;
        ld_d    = is_load_in;
        wen_d   = rf_wr_en_in;
      end
    end
    if ((state_q == StReq) && (dmem_gnt_in || timeout)) req_d = 1'b0;
    if (load_done) begin
      rf_wr_en_d   = wen_q & (|rd_q);
      rf_rd_addr_d = rd_q;
      rf_wr_data_d = load_data;
    end
    if (timeout) bus_err_d = 1'b1;
  end

  assign ready_out      = (state_q == StIdle);
  assign dmem_req_out   = req_q;
  assign dmem_we_out    = we_q;
  assign dmem_addr_out  = addr_q;
  assign dmem_be_out    = be_q;
  assign dmem_wdata_out = wdata_q;
  assign rf_wr_en_out   = rf_wr_en_q;
  assign rf_rd_addr_out = rf_rd_addr_q;
  assign rf_wr_data_out = rf_wr_data_q;
  assign misalign_out   = misalign_q;
  assign bus_err_out    = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, randomized ops against a transaction-level
// model, and hand-written reset-during-transaction sequences.
module tb_mem_wb_stage;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        valid_in, ready_out;
  logic [4:0]  rd_addr_in;
  logic [31:0] alu_result_in, rs2_in, pc_plus_4_in, iadder_in;
  logic [2:0]  wb_mux_sel_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in, is_load_in, is_store_in, rf_wr_en_in;
  logic        dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_gnt_in, dmem_rvalid_in;
  logic [31:0] dmem_rdata_in;
  logic        rf_wr_en_out;
  logic [4:0]  rf_rd_addr_out;
  logic [31:0] rf_wr_data_out;
  logic        misalign_out, bus_err_out;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .rd_addr_in       (rd_addr_in),
    .alu_result_in    (alu_result_in),
    .rs2_in           (rs2_in),
    .pc_plus_4_in     (pc_plus_4_in),
    .iadder_in        (iadder_in),
    .wb_mux_sel_in    (wb_mux_sel_in),
    .load_size_in     (load_size_in),
    .load_unsigned_in (load_unsigned_in),
    .is_load_in       (is_load_in),
    .is_store_in      (is_store_in),
    .rf_wr_en_in      (rf_wr_en_in),
    .dmem_req_out     (dmem_req_out),
    .dmem_we_out      (dmem_we_out),
    .dmem_addr_out    (dmem_addr_out),
    .dmem_be_out      (dmem_be_out),
    .dmem_wdata_out   (dmem_wdata_out),
    .dmem_gnt_in      (dmem_gnt_in),
    .dmem_rvalid_in   (dmem_rvalid_in),
    .dmem_rdata_in    (dmem_rdata_in),
    .rf_wr_en_out     (rf_wr_en_out),
    .rf_rd_addr_out   (rf_rd_addr_out),
    .rf_wr_data_out   (rf_wr_data_out),
    .misalign_out     (misalign_out),
    .bus_err_out      (bus_err_out)
  );

  // g: REQ cycles before gnt; r: cycles from gnt to rvalid (0 = same cycle).
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] alu, rs2, pc4, iadd, rdata;
    logic [2:0]  sel;
    logic [1:0]  size;
    logic        uns, ld, st, wen;
    int          g, r;
    logic        e_mis, e_err, e_wen;
    logic [31:0] e_data, e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int rd, input logic [31:0] alu, input logic [31:0] rs2,
                               input int sel, input int size, input int uns, input int ld,
                               input int st, input int wen, input logic [31:0] rdata,
                               input int g, input int r);
    vec_t v;
    v.rd = 5'(rd); v.alu = alu; v.rs2 = rs2; v.pc4 = 32'h0000_1004; v.iadd = 32'hABCD_E000;
    v.rdata = rdata; v.sel = 3'(sel); v.size = 2'(size); v.uns = 1'(uns); v.ld = 1'(ld);
    v.st = 1'(st); v.wen = 1'(wen); v.g = g; v.r = r;
    v.e_mis = 1'b0; v.e_err = 1'b0; v.e_wen = 1'b0; v.e_data = '0; v.e_wdata = '0; v.e_be = '0;
    return v;
  endfunction

  function automatic vec_t xp(input vec_t v, input int mis, input int err, input int wen,
                              input logic [31:0] data, input int be, input logic [31:0] wdata);
    vec_t o = v;
    o.e_mis = 1'(mis); o.e_err = 1'(err); o.e_wen = 1'(wen);
    o.e_data = data; o.e_be = 4'(be); o.e_wdata = wdata;
    return o;
  endfunction

  // Transaction-level reference: byte counts, modular offsets and arithmetic sign extension.
  function automatic vec_t model(input vec_t v);
    vec_t   o = v;
    int     nb, off, done_idx;
    longint val;
    nb  = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    off = int'(v.alu[1:0]);
    o.e_mis = 1'b0; o.e_err = 1'b0; o.e_wen = 1'b0; o.e_data = '0; o.e_be = '0; o.e_wdata = '0;
    if (!(v.ld || v.st)) begin
      o.e_wen  = v.wen && (v.rd != 5'd0);
      o.e_data = (v.sel == 3'd2) ? v.iadd : (v.sel == 3'd3) ? v.pc4 : v.alu;
    end else if ((off % nb) != 0) begin
      o.e_mis = 1'b1;
    end else begin
      o.e_be = 4'(((1 << nb) - 1) << off);
      if (!v.ld)
        for (int i = 0; i < 4; i++) o.e_wdata[8*i +: 8] = v.rs2[8*(i % nb) +: 8];
      done_idx = v.ld ? v.g + v.r : v.g;
      if (done_idx > int'(T) - 1) begin
        o.e_err = 1'b1;
      end else if (v.ld) begin
        val = longint'(v.rdata >> (8 * off)) & longint'((64'd1 << (8 * nb)) - 64'd1);
        if (!v.uns && val >= longint'(64'd1 << (8 * nb - 1))) val -= longint'(64'd1 << (8 * nb));
        o.e_data = val[31:0];
        o.e_wen  = v.wen && (v.rd != 5'd0);
      end
    end
    return o;
  endfunction

  task automatic run(input vec_t v, input string tag);
    logic ldop, fin;
    int   idx;
    ldop = v.ld;
    @(negedge clk);
    valid_in = 1'b1; rd_addr_in = v.rd; alu_result_in = v.alu; rs2_in = v.rs2;
    pc_plus_4_in = v.pc4; iadder_in = v.iadd; wb_mux_sel_in = v.sel; load_size_in = v.size;
    load_unsigned_in = v.uns; is_load_in = v.ld; is_store_in = v.st; rf_wr_en_in = v.wen;
    dmem_rdata_in = v.rdata;
    dmem_gnt_in = 1'($urandom); dmem_rvalid_in = 1'($urandom);
    chk({tag, " ready_issue"}, 32'(ready_out), 32'd1);
    @(posedge clk); #1;
    valid_in = 1'b0; dmem_gnt_in = 1'b0; dmem_rvalid_in = 1'b0;
    if ((v.ld || v.st) && !v.e_mis) begin
      idx = 0;
      fin = 1'b0;
      while (!fin) begin
        chk({tag, " ready_busy"}, 32'(ready_out), 32'd0);
        chk({tag, " req"}, 32'(dmem_req_out), 32'(idx <= v.g));
        chk({tag, " no_wr_busy"}, 32'({rf_wr_en_out, bus_err_out, misalign_out}), 32'd0);
        if (idx <= v.g) begin
          chk({tag, " addr"}, dmem_addr_out, {v.alu[31:2], 2'b00});
          chk({tag, " we"}, 32'(dmem_we_out), 32'(v.st && !v.ld));
          chk({tag, " be"}, 32'(dmem_be_out), 32'(v.e_be));
          chk({tag, " wdata"}, dmem_wdata_out, v.e_wdata);
        end
        dmem_gnt_in    = (idx == v.g);
        dmem_rvalid_in = ldop && (idx == v.g + v.r);
        fin = (ldop ? (idx == v.g + v.r) : (idx == v.g)) || (idx == int'(T) - 1);
        @(posedge clk); #1;
        dmem_gnt_in = 1'b0; dmem_rvalid_in = 1'b0;
        idx++;
      end
    end
    chk({tag, " misalign"}, 32'(misalign_out), 32'(v.e_mis));
    chk({tag, " bus_err"}, 32'(bus_err_out), 32'(v.e_err));
    chk({tag, " rf_wr_en"}, 32'(rf_wr_en_out), 32'(v.e_wen));
    if (v.e_wen) begin
      chk({tag, " rf_rd"}, 32'(rf_rd_addr_out), 32'(v.rd));
      chk({tag, " rf_data"}, rf_wr_data_out, v.e_data);
    end
    chk({tag, " req_done"}, 32'(dmem_req_out), 32'd0);
    chk({tag, " ready_done"}, 32'(ready_out), 32'd1);
    @(posedge clk); #1;
    chk({tag, " pulse_end"}, 32'({rf_wr_en_out, bus_err_out, misalign_out}), 32'd0);
  endtask

  vec_t tbl[17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   kind, s;
    rst_in = 1'b0; valid_in = 1'b0; rd_addr_in = '0; alu_result_in = '0; rs2_in = '0;
    pc_plus_4_in = '0; iadder_in = '0; wb_mux_sel_in = '0; load_size_in = '0;
    load_unsigned_in = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0; rf_wr_en_in = 1'b0;
    dmem_gnt_in = 1'b0; dmem_rvalid_in = 1'b0; dmem_rdata_in = '0;

    tbl[0]  = xp(mkv(5, 32'h1234, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, 1, 32'h1234, 0, 0);
    tbl[1]  = xp(mkv(3, 32'h103, 0, 1, 0, 0, 1, 0, 1, 32'h80FF_0000, 2, 0),
                 0, 0, 1, 32'hFFFF_FF80, 4'b1000, 0);
    tbl[2]  = xp(mkv(4, 32'h102, 0, 1, 1, 1, 1, 0, 1, 32'hBEEF_1234, 0, 1),
                 0, 0, 1, 32'h0000_BEEF, 4'b1100, 0);
    tbl[3]  = xp(mkv(9, 32'h201, 32'hAB, 0, 0, 0, 0, 1, 0, 0, 3, 0),
                 0, 0, 0, 0, 4'b0010, 32'hABAB_ABAB);
    tbl[4]  = xp(mkv(6, 32'h102, 0, 1, 2, 0, 1, 0, 1, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    tbl[5]  = xp(mkv(0, 32'h100, 0, 1, 2, 0, 1, 0, 1, 32'h1122_3344, 0, 0),
                 0, 0, 0, 0, 4'b1111, 0);
    tbl[6]  = xp(mkv(1, 32'h55, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, 1, 32'h0000_1004, 0, 0);
    tbl[7]  = xp(mkv(7, 32'h55, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, 1, 32'hABCD_E000, 0, 0);
    tbl[8]  = xp(mkv(8, 32'hDEAD_BEEF, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0),
                 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    tbl[9]  = xp(mkv(10, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
    tbl[10] = xp(mkv(11, 32'h40, 0, 1, 2, 0, 1, 0, 1, 32'h5, 1, 5), 0, 1, 0, 0, 4'b1111, 0);
    tbl[11] = xp(mkv(12, 32'h44, 32'h1234_5678, 0, 2, 0, 0, 1, 0, 0, 5, 0),
                 0, 1, 0, 0, 4'b1111, 32'h1234_5678);
    tbl[12] = xp(mkv(13, 32'h301, 32'hBEEF, 0, 1, 0, 0, 1, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    tbl[13] = xp(mkv(14, 32'h40, 32'h99, 1, 2, 0, 1, 1, 1, 32'hCAFE_BABE, 1, 1),
                 0, 0, 1, 32'hCAFE_BABE, 4'b1111, 0);
    tbl[14] = xp(mkv(15, 32'h200, 0, 1, 1, 0, 1, 0, 1, 32'h0000_8001, 1, 0),
                 0, 0, 1, 32'hFFFF_8001, 4'b0011, 0);
    tbl[15] = xp(mkv(16, 32'h10, 0, 1, 2, 0, 1, 0, 1, 32'h0BAD_F00D, 2, 1),
                 0, 0, 1, 32'h0BAD_F00D, 4'b1111, 0);
    tbl[16] = xp(mkv(17, 32'h203, 32'h1234_56C3, 0, 0, 0, 0, 1, 0, 0, 0, 0),
                 0, 0, 0, 0, 4'b1000, 32'hC3C3_C3C3);

    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", 32'(ready_out), 32'd1);
    chk("rst req", 32'(dmem_req_out), 32'd0);
    chk("rst we", 32'(dmem_we_out), 32'd0);
    chk("rst addr", dmem_addr_out, 32'd0);
    chk("rst be", 32'(dmem_be_out), 32'd0);
    chk("rst wdata", dmem_wdata_out, 32'd0);
    chk("rst rf", 32'({rf_wr_en_out, rf_rd_addr_out}), 32'd0);
    chk("rst rf_data", rf_wr_data_out, 32'd0);
    chk("rst flags", 32'({misalign_out, bus_err_out}), 32'd0);
    rst_in = 1'b1;

    // Stray gnt/rvalid while idle must do nothing.
    @(negedge clk);
    dmem_gnt_in = 1'b1; dmem_rvalid_in = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_in = 1'b0; dmem_rvalid_in = 1'b0;
    chk("idle_noise", 32'({dmem_req_out, rf_wr_en_out, bus_err_out}), 32'd0);
    chk("idle_noise ready", 32'(ready_out), 32'd1);

    for (int i = 0; i < 17; i++) run(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 3));
      s    = int'($urandom_range(0, 6));
      v = mkv(int'($urandom_range(0, 31)), (kind == 0) ? $urandom : {20'h0, 12'($urandom)},
              $urandom, (s == 0) ? 0 : s + 1, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)), (kind == 1 || kind == 3) ? 1 : 0,
              (kind >= 2) ? 1 : 0, (kind == 0) ? int'($urandom_range(0, 1)) : 1, $urandom,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      v.pc4  = $urandom;
      v.iadd = $urandom;
      run(model(v), $sformatf("rnd%0d", i));
    end

    // Reset while in REQ: request drops on the reset edge.
    @(negedge clk);
    valid_in = 1'b1; rd_addr_in = 5'd20; alu_result_in = 32'h80; load_size_in = 2'd2;
    is_load_in = 1'b1; is_store_in = 1'b0; rf_wr_en_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("rstreq req", 32'(dmem_req_out), 32'd1);
    rst_in = 1'b0;
    @(posedge clk); #1;
    chk("rstreq req_drop", 32'(dmem_req_out), 32'd0);
    chk("rstreq ready", 32'(ready_out), 32'd1);
    rst_in = 1'b1;

    // Reset while in WAIT: late rvalid afterwards is discarded.
    @(negedge clk);
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; dmem_gnt_in = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_in = 1'b0;
    chk("rstwait in_wait", 32'({ready_out, dmem_req_out}), 32'd0);
    rst_in = 1'b0;
    @(posedge clk); #1;
    chk("rstwait ready", 32'(ready_out), 32'd1);
    chk("rstwait outs", 32'({dmem_req_out, rf_wr_en_out, bus_err_out, misalign_out}), 32'd0);
    rst_in = 1'b1; dmem_rvalid_in = 1'b1; dmem_rdata_in = 32'h1357_9BDF;
    @(posedge clk); #1;
    dmem_rvalid_in = 1'b0;
    chk("late_rvalid wr", 32'(rf_wr_en_out), 32'd0);
    chk("late_rvalid ready", 32'(ready_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
